// File: rtl/hadamard_butterfly_pipelined_pkg.sv
// Shared fixed-point parameters, stage payload types and arithmetic helpers for
// the Hadamard butterfly. C_VAL lives here so every stage uses the same 1/sqrt(2).
package hadamard_butterfly_pipelined_pkg;

   localparam int TOTAL_WIDTH = 8;
   localparam int FRAC_WIDTH  = 4;
   localparam int ADD_WIDTH   = TOTAL_WIDTH + 1;
   localparam int MUL_WIDTH   = ADD_WIDTH + TOTAL_WIDTH;
   localparam int C_VAL       = 11;

   typedef logic signed [TOTAL_WIDTH-1:0] amp_t;
   typedef logic signed [ADD_WIDTH-1:0]   add_t;
   typedef logic signed [MUL_WIDTH-1:0]   mul_t;

   typedef struct packed {
      add_t sum_r;
      add_t sum_i;
      add_t dif_r;
      add_t dif_i;
   } s1_t;

   typedef struct packed {
      mul_t p0_r;
      mul_t p0_i;
      mul_t p1_r;
      mul_t p1_i;
   } s2_t;

   typedef struct packed {
      amp_t y0_r;
      amp_t y0_i;
      amp_t y1_r;
      amp_t y1_i;
   } s3_t;

   // Operands are widened first so a+b and a-b can never wrap.
   function automatic add_t add_ext(input amp_t x, input amp_t y, input logic sub);
      add_t xe;
      add_t ye;
      xe = ADD_WIDTH'(x);
      ye = ADD_WIDTH'(y);
      return sub ? (xe - ye) : (xe + ye);
   endfunction

   function automatic mul_t mul_c(input add_t x);
      mul_t xe;
      mul_t ce;
      xe = MUL_WIDTH'(x);
      ce = MUL_WIDTH'(C_VAL);
      return xe * ce;
   endfunction

endpackage

// File: rtl/hadamard_butterfly_pipelined_fxp_scale_sat.sv
// Drops FRAC_WIDTH fraction bits with a floor shift, then clips the result
// into the signed TOTAL_WIDTH range and reports whether clipping happened.
module fxp_scale_sat
   import hadamard_butterfly_pipelined_pkg::*;
(
   input  logic signed [MUL_WIDTH-1:0]   i_val,
   output logic signed [TOTAL_WIDTH-1:0] o_val,
   output logic                          o_clip
);

   localparam logic signed [MUL_WIDTH-1:0] MAX_V = MUL_WIDTH'(2 ** (TOTAL_WIDTH - 1) - 1);
   localparam logic signed [MUL_WIDTH-1:0] MIN_V = MUL_WIDTH'(-(2 ** (TOTAL_WIDTH - 1)));

   logic signed [MUL_WIDTH-1:0] w_shift;

   assign w_shift = i_val >>> FRAC_WIDTH;

   // Clip the floored value to the output range.
   always_comb begin
      o_val  = '0;
      o_clip = 1'b0;
      if (w_shift > MAX_V) begin
         o_val  = MAX_V[TOTAL_WIDTH-1:0];
         o_clip = 1'b1;
      end else if (w_shift < MIN_V) begin
         o_val  = MIN_V[TOTAL_WIDTH-1:0];
         o_clip = 1'b1;
      end else begin
         o_val  = w_shift[TOTAL_WIDTH-1:0];
         o_clip = 1'b0;
      end
   end

endmodule

// File: rtl/hadamard_butterfly_pipelined.sv
// Three-stage 2-point Hadamard butterfly (add/sub, scale by 1/sqrt(2), floor+saturate)
// with bubble-collapsing valid/ready flow control and a sticky saturation flag.
module hadamard_butterfly_pipelined
   import hadamard_butterfly_pipelined_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [TOTAL_WIDTH-1:0] a_r,
   input  logic signed [TOTAL_WIDTH-1:0] a_i,
   input  logic signed [TOTAL_WIDTH-1:0] b_r,
   input  logic signed [TOTAL_WIDTH-1:0] b_i,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [TOTAL_WIDTH-1:0] y0_r,
   output logic signed [TOTAL_WIDTH-1:0] y0_i,
   output logic signed [TOTAL_WIDTH-1:0] y1_r,
   output logic signed [TOTAL_WIDTH-1:0] y1_i,
   input  logic                          sat_clr,
   output logic                          sat_flag
);

   logic r_v1;
   logic r_v2;
   logic r_v3;
   s1_t  r_s1;
   s2_t  r_s2;
   s3_t  r_s3;
   logic r_sat;

   logic       w_ready1;
   logic       w_ready2;
   logic       w_ready3;
   s1_t        w_s1;
   s2_t        w_s2;
   s3_t        w_s3;
   logic [3:0] w_clip;

   // Any empty stage downstream lets everything upstream of it advance.
   assign w_ready3 = !r_v3 | out_ready;
   assign w_ready2 = !r_v2 | w_ready3;
   assign w_ready1 = !r_v1 | w_ready2;

   assign w_s1.sum_r = add_ext(a_r, b_r, 1'b0);
   assign w_s1.sum_i = add_ext(a_i, b_i, 1'b0);
   assign w_s1.dif_r = add_ext(a_r, b_r, 1'b1);
   assign w_s1.dif_i = add_ext(a_i, b_i, 1'b1);

   assign w_s2.p0_r = mul_c(r_s1.sum_r);
   assign w_s2.p0_i = mul_c(r_s1.sum_i);
   assign w_s2.p1_r = mul_c(r_s1.dif_r);
   assign w_s2.p1_i = mul_c(r_s1.dif_i);

   fxp_scale_sat u_sat_y0_r (.i_val(r_s2.p0_r), .o_val(w_s3.y0_r), .o_clip(w_clip[0]));
   fxp_scale_sat u_sat_y0_i (.i_val(r_s2.p0_i), .o_val(w_s3.y0_i), .o_clip(w_clip[1]));
   fxp_scale_sat u_sat_y1_r (.i_val(r_s2.p1_r), .o_val(w_s3.y1_r), .o_clip(w_clip[2]));
   fxp_scale_sat u_sat_y1_i (.i_val(r_s2.p1_i), .o_val(w_s3.y1_i), .o_clip(w_clip[3]));

   // Pipeline stages: each loads from upstream when ready, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         if (w_ready1) begin
            r_v1 <= in_valid;
            r_s1 <= w_s1;
         end
         if (w_ready2) begin
            r_v2 <= r_v1;
            r_s2 <= w_s2;
         end
         if (w_ready3) begin
            r_v3 <= r_v2;
            r_s3 <= w_s3;
         end
      end
   end

   // Sticky saturation flag; a new clip event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (w_ready3 && r_v2 && (|w_clip)) begin
         r_sat <= 1'b1;
      end else if (sat_clr) begin
         r_sat <= 1'b0;
      end
   end

   assign in_ready  = w_ready1;
   assign out_valid = r_v3;
   assign y0_r      = r_s3.y0_r;
   assign y0_i      = r_s3.y0_i;
   assign y1_r      = r_s3.y1_r;
   assign y1_i      = r_s3.y1_i;
   assign sat_flag  = r_sat;

endmodule

// File: tb/tb_hadamard_butterfly_pipelined.sv
// Self-checking bench for hadamard_butterfly_pipelined: directed cases plus a
// randomized stream compared against an in-order queue reference model.
module tb_hadamard_butterfly_pipelined;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] a_r = 8'sd0, a_i = 8'sd0, b_r = 8'sd0, b_i = 8'sd0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [7:0] y0_r, y0_i, y1_r, y1_i;
   logic              sat_clr = 1'b0;
   logic              sat_flag;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int y0r; int y0i; int y1r; int y1i;
      bit sat;
      int t;
   } entry_t;

   hadamard_butterfly_pipelined dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
      .sat_clr(sat_clr), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   // Reference: floor(s * 11 / 16) clipped to [-128, 127].
   function automatic int floor_scaled(int s);
      int p;
      p = s * 11;
      return (p >= 0) ? (p / 16) : -((-p + 15) / 16);
   endfunction

   function automatic int ref_val(int s);
      int q;
      q = floor_scaled(s);
      if (q > 127) return 127;
      if (q < -128) return -128;
      return q;
   endfunction

   function automatic bit ref_clip(int s);
      int q;
      q = floor_scaled(s);
      return (q > 127) || (q < -128);
   endfunction

   function automatic entry_t make_entry(int ar, int ai, int br, int bi, int t);
      entry_t e;
      e.y0r = ref_val(ar + br);
      e.y0i = ref_val(ai + bi);
      e.y1r = ref_val(ar - br);
      e.y1i = ref_val(ai - bi);
      e.sat = ref_clip(ar + br) | ref_clip(ai + bi) | ref_clip(ar - br) | ref_clip(ai - bi);
      e.t   = t;
      return e;
   endfunction

   // Send one pair into an empty pipeline and capture the first output.
   task automatic xfer(input int ar, input int ai, input int br, input int bi,
                       output int o0r, output int o0i, output int o1r, output int o1i,
                       output int lat, output bit sat);
      a_r = 8'(ar); a_i = 8'(ai); b_r = 8'(br); b_i = 8'(bi);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; o0r = 0; o0i = 0; o1r = 0; o1i = 0; sat = 1'b0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            o0r = int'(y0_r); o0i = int'(y0_i); o1r = int'(y1_r); o1i = int'(y1_i);
            sat = sat_flag;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1; in_valid = 1'b1; a_r = 8'sd50; a_i = 8'sd20; b_r = -8'sd7; b_i = 8'sd3;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || y0_r !== 8'sd0 || y0_i !== 8'sd0 || y1_r !== 8'sd0 ||
          y1_i !== 8'sd0 || sat_flag !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state: out_valid=%b y=%0d,%0d,%0d,%0d sat=%b required 0 and zeros",
                  out_valid, y0_r, y0_i, y1_r, y1_i, sat_flag);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++;
         $display("FAIL reset_no_emit: got %0d outputs required 0", seen);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int o0r, o0i, o1r, o1i, lat;
      bit s;
      xfer(16, 0, 16, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (lat != 3 || o0r != 22 || o0i != 0 || o1r != 0 || o1i != 0) begin
         n_errors++;
         $display("FAIL basic_real: lat=%0d y=%0d,%0d,%0d,%0d required 3 22,0,0,0", lat, o0r, o0i, o1r, o1i);
      end
      xfer(16, 0, 0, 16, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (lat != 3 || o0r != 11 || o0i != 11 || o1r != 11 || o1i != -11) begin
         n_errors++;
         $display("FAIL basic_cplx: lat=%0d y=%0d,%0d,%0d,%0d required 3 11,11,11,-11", lat, o0r, o0i, o1r, o1i);
      end
   endtask

   task automatic test_floor();
      int o0r, o0i, o1r, o1i, lat;
      bit s;
      xfer(1, 0, 0, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (o0r != 0 || o1r != 0) begin
         n_errors++;
         $display("FAIL floor_pos: y0_r=%0d y1_r=%0d required 0 0", o0r, o1r);
      end
      xfer(-1, 0, 0, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (o0r != -1 || o1r != -1 || o0i != 0) begin
         n_errors++;
         $display("FAIL floor_neg: y0_r=%0d y1_r=%0d y0_i=%0d required -1 -1 0", o0r, o1r, o0i);
      end
   endtask

   task automatic test_saturation();
      int o0r, o0i, o1r, o1i, lat;
      bit s;
      xfer(127, 0, 127, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (o0r != 127 || o1r != 0 || s !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_pos: y0_r=%0d y1_r=%0d flag=%b required 127 0 1", o0r, o1r, s);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (sat_flag !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_sticky: got %b required 1", sat_flag);
      end
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_errors++;
         $display("FAIL sat_clear: got %b required 0", sat_flag);
      end
      xfer(-128, 0, -128, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (o0r != -128 || o1r != 0 || s !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_neg: y0_r=%0d y1_r=%0d flag=%b required -128 0 1", o0r, o1r, s);
      end
      // Clear held high across a saturating load: the set must win.
      sat_clr = 1'b1;
      xfer(127, 0, 127, 0, o0r, o0i, o1r, o1i, lat, s);
      n_checks++;
      if (s !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_set_wins: got %b required 1", s);
      end
      sat_clr = 1'b0;
      n_checks++;
      if (sat_flag !== 1'b0) begin
         n_errors++;
         $display("FAIL sat_clr_after: got %b required 0", sat_flag);
      end
   endtask

   task automatic test_backpressure();
      int pa[6][4];
      entry_t e;
      int acc, got, hold0r, hold1i;
      for (int i = 0; i < 6; i++) begin
         pa[i][0] = 10 * i + 3; pa[i][1] = -5 * i; pa[i][2] = 7 - 9 * i; pa[i][3] = 2 * i + 1;
      end
      acc = 0; got = 0; hold0r = 0; hold1i = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (acc < 6);
         a_r = 8'(pa[acc][0]); a_i = 8'(pa[acc][1]); b_r = 8'(pa[acc][2]); b_i = 8'(pa[acc][3]);
         @(negedge clk);
         if (c == 4) begin hold0r = int'(y0_r); hold1i = int'(y1_i); end
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a_r = 8'(pa[acc][0]); a_i = 8'(pa[acc][1]); b_r = 8'(pa[acc][2]); b_i = 8'(pa[acc][3]);
      @(negedge clk);
      e = make_entry(pa[0][0], pa[0][1], pa[0][2], pa[0][3], 0);
      n_checks++;
      if (acc != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_fill: accepts=%0d in_ready=%b out_valid=%b required 3 0 1", acc, in_ready, out_valid);
      end
      n_checks++;
      if (int'(y0_r) != hold0r || int'(y1_i) != hold1i || hold0r != e.y0r || hold1i != e.y1i) begin
         n_errors++;
         $display("FAIL bp_hold: y0_r=%0d/%0d y1_i=%0d/%0d required %0d %0d",
                  hold0r, y0_r, hold1i, y1_i, e.y0r, e.y1i);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && got < 6; c++) begin
         in_valid = (acc < 6);
         if (acc < 6) begin
            a_r = 8'(pa[acc][0]); a_i = 8'(pa[acc][1]); b_r = 8'(pa[acc][2]); b_i = 8'(pa[acc][3]);
         end
         @(negedge clk);
         if (out_valid) begin
            e = make_entry(pa[got][0], pa[got][1], pa[got][2], pa[got][3], 0);
            n_checks++;
            if (int'(y0_r) != e.y0r || int'(y0_i) != e.y0i || int'(y1_r) != e.y1r || int'(y1_i) != e.y1i) begin
               n_errors++;
               $display("FAIL bp_order[%0d]: y=%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d", got,
                        y0_r, y0_i, y1_r, y1_i, e.y0r, e.y0i, e.y1r, e.y1i);
            end
            got++;
         end
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got != 6 || acc != 6 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_drain: outputs=%0d accepts=%0d out_valid=%b required 6 6 0", got, acc, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      entry_t q[$];
      entry_t e;
      bit exp_sat, exp_ov, exp_ir, popped, loaded;
      int rst_hold, bad;
      exp_sat = 1'b0; rst_hold = 0; bad = 0;
      for (int n = 0; n < 10000; n++) begin
         if (n == 0) begin
            rst = 1'b1;
         end else if (rst_hold > 0) begin
            rst = 1'b1; rst_hold--;
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1; rst_hold = $urandom_range(0, 2);
         end else begin
            rst = 1'b0;
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         sat_clr   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 0) begin
            a_r = 8'($urandom); a_i = 8'($urandom); b_r = 8'($urandom); b_i = 8'($urandom);
         end else begin
            a_r = 8'($urandom_range(0, 60)) - 8'sd30; a_i = 8'($urandom_range(0, 60)) - 8'sd30;
            b_r = 8'($urandom_range(0, 60)) - 8'sd30; b_i = 8'($urandom_range(0, 60)) - 8'sd30;
         end
         @(negedge clk);
         exp_ir = (q.size() < 3) || out_ready;
         exp_ov = (q.size() > 0) && (n >= q[0].t + 3);
         n_checks++;
         if (in_ready !== exp_ir || out_valid !== exp_ov || sat_flag !== exp_sat) begin
            n_errors++;
            if (bad < 10) $display("FAIL rnd_ctrl @%0d: in_ready=%b out_valid=%b sat=%b required %b %b %b",
                                   n, in_ready, out_valid, sat_flag, exp_ir, exp_ov, exp_sat);
            bad++;
         end
         if (exp_ov) begin
            n_checks++;
            if (int'(y0_r) != q[0].y0r || int'(y0_i) != q[0].y0i ||
                int'(y1_r) != q[0].y1r || int'(y1_i) != q[0].y1i) begin
               n_errors++;
               if (bad < 10) $display("FAIL rnd_data @%0d: y=%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d", n,
                                      y0_r, y0_i, y1_r, y1_i, q[0].y0r, q[0].y0i, q[0].y1r, q[0].y1i);
               bad++;
            end
         end
         if (rst) begin
            q.delete();
            exp_sat = 1'b0;
         end else begin
            popped = exp_ov && out_ready;
            if (popped) void'(q.pop_front());
            if (in_valid && exp_ir) begin
               e = make_entry(int'(a_r), int'(a_i), int'(b_r), int'(b_i), n);
               q.push_back(e);
            end
            loaded = (q.size() > 0) && (popped || !exp_ov) && (n + 1 >= q[0].t + 3);
            if (loaded && q[0].sat) exp_sat = 1'b1;
            else if (sat_clr) exp_sat = 1'b0;
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_floor();
      test_saturation();
      test_backpressure();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hadamard_butterfly_pipelined.md
Name: hadamard_butterfly_pipelined

Overview:
- Pipelined 2-point Hadamard butterfly on complex fixed-point amplitudes.
- Computes y0 = (a+b)·C and y1 = (a−b)·C, with C = 1/√2 in S4.4.
- Sits directly downstream of the pi/4 controlled-rotation stage in the reduced QFT pipeline.
- Unlike the rotation stage, it has valid/ready flow control, bubble-collapsing stalls and output saturation.

Parameters:
- TOTAL_WIDTH, 8, amplitude width (S4.4), taken from fixed_point_params.vh.
- FRAC_WIDTH, 4, fractional bits.
- ADD_WIDTH, TOTAL_WIDTH+1, width of the sum/difference.
- C_VAL, 11, 1/√2 constant in S4.4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept the input pair this cycle.
- a_r, a_i, b_r, b_i  in  TOTAL_WIDTH each  signed input amplitudes.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output pair.
- y0_r, y0_i, y1_r, y1_i  out  TOTAL_WIDTH each  signed results.
- sat_clr  in  1  clears sat_flag.
- sat_flag  out  1  sticky: some output component has saturated.

Behaviour:
- Three register stages S1/S2/S3, each holding a data register and a valid bit v1/v2/v3.
- S1 computes four ADD_WIDTH sums/differences: a_r+b_r, a_i+b_i, a_r−b_r, a_i−b_i, with sign extension before the add.
- S2 multiplies each by C_VAL to full width ADD_WIDTH+TOTAL_WIDTH; no overflow is possible.
- S3 applies an arithmetic shift right by FRAC_WIDTH (floor, no rounding).
  - It then saturates to [−2^(TOTAL_WIDTH−1), 2^(TOTAL_WIDTH−1)−1] = [−128, 127].
- Handshake is bubble-collapsing:
  - ready3 = !v3 | out_ready.
  - ready2 = !v2 | ready3.
  - ready1 = !v1 | ready2.
  - in_ready = ready1; combinational, no dependency on in_valid.
- Stage k loads from stage k−1 when ready_k. v_k is then set to v_(k−1); for S1 it is set to in_valid.
- A stage whose ready is low holds both data and valid.
- Transfer rules:
  - A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
  - Data is never dropped or duplicated.
  - Outputs are stable while out_valid & !out_ready.
- Latency: 3 cycles from input acceptance to out_valid with no stall.
- Throughput is 1 pair/cycle with out_ready held high.
- out_valid = v3. The y* outputs come directly from the S3 registers.
- sat_flag:
  - Set in the cycle S3 loads a valid entry whose value for any of the four components was clipped.
  - sat_clr clears it.
  - If sat_clr and a new saturation event occur in the same cycle, the set wins.
- Reset (synchronous, rst=1):
  - v1, v2, v3 = 0; all data registers = 0; sat_flag = 0.
  - Hence out_valid = 0 and y* = 0 in the cycle after reset.
  - in_ready = 1 once reset deasserts.
- Reset mid-operation discards all in-flight entries. Inputs presented while rst=1 are not accepted.
- Bubbles: an invalid S2 entry does not block S1. A downstream stall fills empty stages before in_ready falls.
- With out_ready held low from empty, exactly 3 pairs are accepted, then in_ready = 0.

Decomposition:
- fixed_point_params.vh supplies TOTAL_WIDTH, FRAC_WIDTH and ADD_WIDTH.
- C_VAL moves into that shared header so the rotation and butterfly stages share one constant.
- One sub-module is natural: fxp_scale_sat.
  - Combinational: arithmetic shift by FRAC_WIDTH, then clip to TOTAL_WIDTH.
  - Outputs a per-value clip flag.
  - Instantiated four times in S3.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, y*=0, sat_flag=0, nothing emitted after release.
- Basic:
  - a=(16,0), b=(16,0) -> after 3 cycles y0=(22,0), y1=(0,0).
  - a=(16,0), b=(0,16) -> y0=(11,11), y1=(11,−11).
- Floor rounding: a=(1,0), b=(0,0) -> y0_r=0; a=(−1,0), b=(0,0) -> y0_r=−1, y1_r=−1.
- Saturation:
  - a=(127,0), b=(127,0) -> y0_r=127 (raw 174), sat_flag=1, held until sat_clr.
  - a=(−128,0), b=(−128,0) -> y0_r=−128 (raw −176).
- Backpressure:
  - Stream of 6 distinct pairs with out_ready=0 for cycles 2–7 -> in_ready=0 after exactly 3 accepts.
  - Outputs are held stable; all 6 results emerge in order after out_ready=1, none lost or duplicated.
- Random: 10k random inputs with random in_valid/out_ready against a reference model; includes rst pulses mid-stream (flush checked) and sat_clr coincident with a saturation event (flag stays 1).
